exec_mem_core: RTL and testbench
================================

// Module: exec_mem_core
// PURPOSE
//  Datapath core of the 8-bit single-cycle CPU: PC register, 2-bit-op ALU with
//  NZCV flags, and byte-wide data memory addressed by the ALU result.
//  Sits between register file/control unit (operands, ALU op, write enable) and
//  the writeback/next-PC muxes (ALU result, memory read data, PC).
//  Single clock domain.
// PARAMETERS
//  DATA_W  8    datapath, PC and memory word width (bits)
//  ADDR_W  8    memory address width; address = alu_result[ADDR_W-1:0]
//  DEPTH   256  number of data memory words (<= 2**ADDR_W)
// PORTS
//  clk         in   1       clock, rising-edge active
//  rst_n       in   1       asynchronous active-low reset
//  pc_in       in   DATA_W  next PC value
//  pc_out      out  DATA_W  registered PC
//  alu_a       in   DATA_W  operand A (register read 1)
//  alu_b       in   DATA_W  operand B (register read 2)
//  alu_ctrl    in   2       00 ADD, 01 SUB, 10 AND, 11 OR
//  alu_result  out  DATA_W  combinational ALU result; also memory address
//  alu_flags   out  4       {N,Z,C,V}, combinational
//  mem_we      in   1       data memory write enable
//  mem_wdata   in   DATA_W  store data (register read 2)
//  mem_rdata   out  DATA_W  combinational read of mem[alu_result]
// BEHAVIOUR
//  Reset (rst_n low, asynchronous, no clock needed):
//   - pc_out = 0 immediately.
//   - All DEPTH memory words cleared to 0.
//   - Writes blocked while rst_n is low.
//   - On release, the first rising edge loads pc_in.
//  PC:
//   - pc_out <= pc_in on every rising clk edge; no enable.
//   - 1-cycle latency.
//  ALU, purely combinational, zero latency:
//   - ADD: result = a+b mod 2^DATA_W; C = carry out;
//     V = signed overflow (a,b same sign, result sign differs).
//   - SUB: result = a-b mod 2^DATA_W, computed as a + ~b + 1;
//     C = 1 when no borrow (a >= b unsigned); V = (a,b signs differ, result sign != a sign).
//   - AND / OR: bitwise; C = 0, V = 0.
//   - N = result[DATA_W-1]; Z = (result == 0) for all ops.
//  Data memory:
//   - Address = alu_result[ADDR_W-1:0].
//   - Read is asynchronous.
//   - Write: at rising clk with mem_we=1 and rst_n=1, mem[addr] <= mem_wdata.
//   - Write and read of the same address in one cycle: mem_rdata shows old data
//     until the edge, new data after it.
//   - Address >= DEPTH: read returns 0; write ignored.
//   - Address wrap follows alu_result wrap; no exceptions.
//  Reset asserted mid-cycle overrides any pending write and the PC load.
// TESTING
//  1. rst_n=0 with pc_in=8'h05 and clocks running -> pc_out=0; release, one edge -> pc_out=05.
//  2. Walk pc_in 00..08, one per cycle -> pc_out tracks pc_in one cycle later.
//  3. ALU vectors:
//     ADD 7F+01 -> 80, NZCV=1001; ADD FF+01 -> 00, NZCV=0110;
//     SUB 05-05 -> 00, NZCV=0110; SUB 03-05 -> FE, NZCV=1000.
//  4. AND F0&3C -> 30, NZCV=0000; OR 00|00 -> 00, NZCV=0100.
//  5. ADD 10+04 with mem_we=1, wdata=AB -> mem_rdata=AB after the edge;
//     then mem_we=0, same address -> AB held; other address -> 00.
//  6. Write 5A to addr 14, then pulse rst_n low mid-cycle -> mem_rdata at 14 = 00,
//     pc_out = 00 without a clock edge.

Source files
------------

// File: rtl/exec_mem_if.sv
// exec_mem_if: operand/control inputs and result/PC/memory outputs of the execute-memory core
interface exec_mem_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] pc_in, pc_out, alu_a, alu_b, alu_result, mem_wdata, mem_rdata;
    logic [1:0] alu_ctrl;
    logic [3:0] alu_flags;
    logic mem_we;
    modport master (
        output pc_in, alu_a, alu_b, alu_ctrl, mem_we, mem_wdata,
        input  pc_out, alu_result, alu_flags, mem_rdata
    );
    modport slave (
        input  pc_in, alu_a, alu_b, alu_ctrl, mem_we, mem_wdata,
        output pc_out, alu_result, alu_flags, mem_rdata
    );
endinterface

// File: rtl/exec_mem_core.sv
// exec_mem_core: PC register, 2-bit-op ALU with NZCV flags, and byte-wide data memory addressed by the ALU result
module exec_mem_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input logic clk,
    input logic rst_n,
    exec_mem_if.slave bus
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] b_eff, res;
    logic [DATA_W:0] sum;
    logic [ADDR_W-1:0] addr;
    logic logic_op, hit;
    // SUB reuses the adder as a + ~b + 1, so C is the not-borrow and V uses the inverted operand
    assign logic_op = bus.alu_ctrl[1];
    assign b_eff = bus.alu_ctrl[0] ? ~bus.alu_b : bus.alu_b;
    assign sum = {1'b0, bus.alu_a} + {1'b0, b_eff} + (DATA_W+1)'(bus.alu_ctrl[0]);
    assign res = logic_op ? (bus.alu_ctrl[0] ? bus.alu_a | bus.alu_b : bus.alu_a & bus.alu_b) : sum[DATA_W-1:0];
    assign bus.alu_result = res;
    assign bus.alu_flags = {
        res[DATA_W-1],
        res == '0,
        ~logic_op & sum[DATA_W],
        ~logic_op & (bus.alu_a[DATA_W-1] == b_eff[DATA_W-1]) & (res[DATA_W-1] != bus.alu_a[DATA_W-1])
    };
    assign addr = res[ADDR_W-1:0];
    assign hit = int'(addr) < DEPTH;
    assign bus.mem_rdata = hit ? mem[addr] : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pc_out <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            bus.pc_out <= bus.pc_in;
            if (bus.mem_we && hit) mem[addr] <= bus.mem_wdata;
        end
    end
endmodule

// File: tb/tb_exec_mem_core.sv
// tb_exec_mem_core: directed checks of reset, PC, ALU and memory followed by random traffic against a reference model
module tb_exec_mem_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [7:0] ref_mem [256];
    logic [7:0] ref_pc;
    exec_mem_if #(.DATA_W(8)) bus ();
    exec_mem_core dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // Reference ALU from arithmetic definitions: unsigned sums for C, signed sums for V
    task automatic alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                           output logic [7:0] r, output logic [3:0] f);
        int ua, ub, sa, sb, s, sv;
        logic c, v;
        ua = int'(a); ub = int'(b);
        sa = ua > 127 ? ua - 256 : ua;
        sb = ub > 127 ? ub - 256 : ub;
        c = 1'b0; v = 1'b0;
        case (op)
            2'd0: begin s = ua + ub; sv = sa + sb; c = s > 255; v = sv > 127 || sv < -128; end
            2'd1: begin s = ua - ub; sv = sa - sb; c = ua >= ub; v = sv > 127 || sv < -128; end
            2'd2: s = int'(a & b);
            default: s = int'(a | b);
        endcase
        r = 8'(s);
        f = {r[7], r == 8'd0, c, v};
    endtask
    task automatic set_alu(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        bus.alu_a = a; bus.alu_b = b; bus.alu_ctrl = op;
    endtask
    task automatic step;
        @(posedge clk);
        if (rst_n) begin
            ref_pc = bus.pc_in;
            if (bus.mem_we) ref_mem[bus.alu_result] = bus.mem_wdata;
        end
        #1;
    endtask
    task automatic check_vec(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                             input logic [7:0] er, input logic [3:0] ef);
        logic [7:0] r;
        logic [3:0] f;
        set_alu(a, b, op);
        #1;
        alu_ref(a, b, op, r, f);
        check({tag, "_model"}, {20'd0, r, f}, {20'd0, er, ef});
        check({tag, "_res"}, 32'(bus.alu_result), 32'(er));
        check({tag, "_flags"}, 32'(bus.alu_flags), 32'(ef));
    endtask
    initial begin
        logic [7:0] r;
        logic [3:0] f;
        foreach (ref_mem[i]) ref_mem[i] = 8'd0;
        ref_pc = 8'd0;
        bus.pc_in = 8'h05; bus.mem_we = 1'b1; bus.mem_wdata = 8'hEE;
        set_alu(8'h10, 8'h04, 2'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", 32'(bus.pc_out), 32'h00);
        check("rst_mem_blocked", 32'(bus.mem_rdata), 32'h00);
        @(negedge clk);
        bus.mem_we = 1'b0;
        rst_n = 1'b1;
        step();
        check("rst_release_pc", 32'(bus.pc_out), 32'h05);
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            bus.pc_in = 8'(i);
            step();
            check($sformatf("pc_walk_%0d", i), 32'(bus.pc_out), 32'(i));
        end
        @(negedge clk);
        check_vec("add_7f_01", 8'h7F, 8'h01, 2'd0, 8'h80, 4'b1001);
        check_vec("add_ff_01", 8'hFF, 8'h01, 2'd0, 8'h00, 4'b0110);
        check_vec("sub_05_05", 8'h05, 8'h05, 2'd1, 8'h00, 4'b0110);
        check_vec("sub_03_05", 8'h03, 8'h05, 2'd1, 8'hFE, 4'b1000);
        check_vec("and_f0_3c", 8'hF0, 8'h3C, 2'd2, 8'h30, 4'b0000);
        check_vec("or_00_00", 8'h00, 8'h00, 2'd3, 8'h00, 4'b0100);
        set_alu(8'h10, 8'h04, 2'd0);
        bus.mem_we = 1'b1; bus.mem_wdata = 8'hAB;
        #1;
        check("wr_old_before_edge", 32'(bus.mem_rdata), 32'h00);
        step();
        check("wr_new_after_edge", 32'(bus.mem_rdata), 32'hAB);
        @(negedge clk);
        bus.mem_we = 1'b0;
        step();
        check("wr_held", 32'(bus.mem_rdata), 32'hAB);
        @(negedge clk);
        set_alu(8'h10, 8'h05, 2'd0);
        #1;
        check("other_addr", 32'(bus.mem_rdata), 32'h00);
        set_alu(8'h14, 8'h00, 2'd0);
        bus.mem_we = 1'b1; bus.mem_wdata = 8'h5A; bus.pc_in = 8'h33;
        step();
        check("wr_5a", 32'(bus.mem_rdata), 32'h5A);
        check("pc_before_rst", 32'(bus.pc_out), 32'h33);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_mem", 32'(bus.mem_rdata), 32'h00);
        check("async_rst_pc", 32'(bus.pc_out), 32'h00);
        foreach (ref_mem[i]) ref_mem[i] = 8'd0;
        ref_pc = 8'd0;
        step();
        check("rst_blocks_write", 32'(bus.mem_rdata), 32'h00);
        check("rst_blocks_pc", 32'(bus.pc_out), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_we = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic [7:0] ra, rb, old;
            @(negedge clk);
            ra = 8'($urandom_range(0, 255));
            rb = n < 150 ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            set_alu(ra, rb, 2'($urandom_range(0, 3)));
            bus.mem_we = 1'($urandom_range(0, 1));
            bus.mem_wdata = 8'($urandom_range(0, 255));
            bus.pc_in = 8'($urandom_range(0, 255));
            #1;
            alu_ref(ra, rb, bus.alu_ctrl, r, f);
            old = ref_mem[r];
            check($sformatf("rnd%0d_res", n), 32'(bus.alu_result), 32'(r));
            check($sformatf("rnd%0d_flags", n), 32'(bus.alu_flags), 32'(f));
            check($sformatf("rnd%0d_rd_pre", n), 32'(bus.mem_rdata), 32'(old));
            step();
            check($sformatf("rnd%0d_pc", n), 32'(bus.pc_out), 32'(ref_pc));
            check($sformatf("rnd%0d_rd_post", n), 32'(bus.mem_rdata), 32'(ref_mem[r]));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
